// File: rtl/bist_pkg.sv
// Shared definitions for the BIST response-compaction stage: FSM encodings,
// the default MISR polynomial and the round-counter width.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_COMPARE = 2'd2,
        ST_RESULT  = 2'd3
    } state_t;

    localparam logic [15:0] MISR_POLY16 = 16'h1021;
    localparam int          RND_W       = 16;

    // The round counter sticks at all-ones rather than wrapping back to zero.
    function automatic logic [RND_W-1:0] sat_inc(input logic [RND_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/misr_signature_checker_if.sv
// Controller/tester-facing bundle of the signature checker: compaction
// strobes and response data in, signature, round count and verdict out.
interface misr_signature_checker_if
    import bist_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic             rstOut;
    logic             MISR_En;
    logic             done;
    logic [WIDTH-1:0] resp;
    logic [WIDTH-1:0] signature;
    logic [RND_W-1:0] round_count;
    logic             sig_valid;
    logic             pass;
    logic             fail;

    modport master (
        output rstOut, MISR_En, done, resp,
        input  signature, round_count, sig_valid, pass, fail
    );

    modport slave (
        input  rstOut, MISR_En, done, resp,
        output signature, round_count, sig_valid, pass, fail
    );

endinterface

// File: rtl/misr_signature_checker_core.sv
// Galois shift-left MISR; a clear reloads SEED and wins over compaction.
// Kept free of checker logic so the scan-path SISA can reuse it.
module misr_core
    import bist_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(MISR_POLY16),
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             rstIn,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig
);

    logic [WIDTH-1:0] sig_d;
    logic [WIDTH-1:0] sig_q;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = SEED;
        end else if (en) begin
            sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ din;
        end
    end

    always_ff @(posedge clk or posedge rstIn) begin
        if (rstIn) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/misr_signature_checker.sv
// Compacts CUT responses into a MISR, counts rounds, and on done latches a
// sticky pass/fail verdict against the build-time golden signature and count.
module misr_signature_checker
    import bist_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] POLY       = WIDTH'(MISR_POLY16),
    parameter logic [WIDTH-1:0] SEED       = '0,
    parameter logic [WIDTH-1:0] GOLDEN     = '0,
    parameter int unsigned      NUM_ROUNDS = 50
) (
    input  logic                      clk,
    input  logic                      rstIn,
    misr_signature_checker_if.slave   bus
);

    localparam logic [RND_W-1:0] ROUNDS_EXP = RND_W'(NUM_ROUNDS);

    state_t           state_d, state_q;
    logic [RND_W-1:0] cnt_d, cnt_q;
    logic             valid_d, valid_q;
    logic             pass_d, pass_q;
    logic             fail_d, fail_q;
    logic             misr_en;
    logic [WIDTH-1:0] sig;

    misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk   (clk),
        .rstIn (rstIn),
        .clr   (bus.rstOut),
        .en    (misr_en),
        .din   (bus.resp),
        .sig   (sig)
    );

    // rstOut outranks everything; compaction is only live before the compare,
    // so the verdict always sees the signature as it stood when done arrived.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        misr_en = 1'b0;
        if (bus.rstOut) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_COMPACT: begin
                    if (bus.MISR_En) begin
                        misr_en = 1'b1;
                        cnt_d   = sat_inc(cnt_q);
                        state_d = ST_COMPACT;
                    end
                    if (bus.done) begin
                        state_d = ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    pass_d  = (sig == GOLDEN) && (cnt_q == ROUNDS_EXP);
                    fail_d  = !((sig == GOLDEN) && (cnt_q == ROUNDS_EXP));
                    valid_d = 1'b1;
                    state_d = ST_RESULT;
                end
                ST_RESULT: begin
                    state_d = ST_RESULT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rstIn) begin
        if (rstIn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    assign bus.signature   = sig;
    assign bus.round_count = cnt_q;
    assign bus.sig_valid   = valid_q;
    assign bus.pass        = pass_q;
    assign bus.fail        = fail_q;

endmodule

// File: tb/tb_misr_signature_checker.sv
// Directed bench for misr_signature_checker: one default instance (SEED 0,
// GOLDEN 0, 50 rounds) and one with SEED 16'h8000 to exercise the feedback tap.
module tb_misr_signature_checker;

    logic clk;
    logic rstIn;
    int   checks;
    int   errors;
    logic [15:0] model_sig;

    misr_signature_checker_if #(.WIDTH(16)) bus_a ();
    misr_signature_checker_if #(.WIDTH(16)) bus_b ();

    misr_signature_checker #(
        .WIDTH      (16),
        .POLY       (16'h1021),
        .SEED       (16'h0000),
        .GOLDEN     (16'h0000),
        .NUM_ROUNDS (50)
    ) dut_a (
        .clk   (clk),
        .rstIn (rstIn),
        .bus   (bus_a.slave)
    );

    misr_signature_checker #(
        .WIDTH      (16),
        .POLY       (16'h1021),
        .SEED       (16'h8000),
        .GOLDEN     (16'h0000),
        .NUM_ROUNDS (50)
    ) dut_b (
        .clk   (clk),
        .rstIn (rstIn),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference Galois shift-left step with the 16'h1021 polynomial.
    function automatic logic [15:0] misrModel(input logic [15:0] s, input logic [15:0] r);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle on instance A with the given strobe, response and done level.
    task automatic applyStimulus(input logic en, input logic [15:0] r, input logic dn);
        bus_a.MISR_En = en;
        bus_a.resp    = r;
        bus_a.done    = dn;
        tick();
    endtask

    task automatic clearA();
        bus_a.rstOut  = 1'b1;
        bus_a.MISR_En = 1'b0;
        bus_a.done    = 1'b0;
        tick();
        bus_a.rstOut  = 1'b0;
    endtask

    // Response pairs (1, 2) bring a zero signature back to zero.
    task automatic runPairs(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 16'h0001, 1'b0);
            applyStimulus(1'b1, 16'h0002, 1'b0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstIn  = 1'b1;
        bus_a.rstOut = 1'b0; bus_a.MISR_En = 1'b0; bus_a.done = 1'b0; bus_a.resp = '0;
        bus_b.rstOut = 1'b0; bus_b.MISR_En = 1'b0; bus_b.done = 1'b0; bus_b.resp = '0;
        tick();
        tick();

        checkOutput("reset_sig",   bus_a.signature,   16'h0000);
        checkOutput("reset_cnt",   bus_a.round_count, 16'h0000);
        checkOutput("reset_valid", bus_a.sig_valid,   1'b0);
        checkOutput("reset_pass",  bus_a.pass,        1'b0);
        checkOutput("reset_fail",  bus_a.fail,        1'b0);
        checkOutput("reset_sig_b", bus_b.signature,   16'h8000);
        rstIn = 1'b0;
        tick();

        applyStimulus(1'b1, 16'h0001, 1'b0);
        checkOutput("basic_sig1", bus_a.signature,   16'h0001);
        applyStimulus(1'b1, 16'h0001, 1'b0);
        checkOutput("basic_sig2", bus_a.signature,   16'h0003);
        checkOutput("basic_cnt2", bus_a.round_count, 16'd2);

        bus_b.rstOut = 1'b1;
        tick();
        bus_b.rstOut = 1'b0;
        checkOutput("tap_seed", bus_b.signature, 16'h8000);
        bus_b.MISR_En = 1'b1;
        bus_b.resp    = 16'h0000;
        tick();
        bus_b.MISR_En = 1'b0;
        checkOutput("tap_sig", bus_b.signature,   16'h1021);
        checkOutput("tap_cnt", bus_b.round_count, 16'd1);

        bus_a.rstOut  = 1'b1;
        bus_a.MISR_En = 1'b1;
        bus_a.resp    = 16'hFFFF;
        bus_a.done    = 1'b1;
        tick();
        bus_a.rstOut = 1'b0; bus_a.MISR_En = 1'b0; bus_a.done = 1'b0;
        checkOutput("clr_compact_sig",   bus_a.signature,   16'h0000);
        checkOutput("clr_compact_cnt",   bus_a.round_count, 16'd0);
        checkOutput("clr_compact_valid", bus_a.sig_valid,   1'b0);

        applyStimulus(1'b1, 16'h0001, 1'b0);
        checkOutput("pass_first_sig", bus_a.signature, 16'h0001);
        applyStimulus(1'b1, 16'h0002, 1'b0);
        checkOutput("pass_pair_sig", bus_a.signature, 16'h0000);
        runPairs(24);
        checkOutput("pass_sig50", bus_a.signature,   16'h0000);
        checkOutput("pass_cnt50", bus_a.round_count, 16'd50);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("lat_valid_n", bus_a.sig_valid, 1'b0);
        checkOutput("lat_pass_n",  bus_a.pass,      1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("lat_valid_n1", bus_a.sig_valid, 1'b1);
        checkOutput("lat_pass_n1",  bus_a.pass,      1'b1);
        checkOutput("lat_fail_n1",  bus_a.fail,      1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h0005, 1'b1);
        checkOutput("hold_sig",   bus_a.signature,   16'h0000);
        checkOutput("hold_cnt",   bus_a.round_count, 16'd50);
        checkOutput("hold_valid", bus_a.sig_valid,   1'b1);
        checkOutput("hold_pass",  bus_a.pass,        1'b1);

        bus_a.rstOut = 1'b1; bus_a.MISR_En = 1'b1; bus_a.resp = 16'h0007; bus_a.done = 1'b1;
        tick();
        bus_a.rstOut = 1'b0; bus_a.MISR_En = 1'b0; bus_a.done = 1'b0;
        checkOutput("clr_result_sig",   bus_a.signature,   16'h0000);
        checkOutput("clr_result_cnt",   bus_a.round_count, 16'd0);
        checkOutput("clr_result_valid", bus_a.sig_valid,   1'b0);
        checkOutput("clr_result_pass",  bus_a.pass,        1'b0);
        checkOutput("clr_result_fail",  bus_a.fail,        1'b0);

        runPairs(24);
        applyStimulus(1'b1, 16'h0000, 1'b0);
        checkOutput("cnt49_sig", bus_a.signature,   16'h0000);
        checkOutput("cnt49_cnt", bus_a.round_count, 16'd49);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("cnt49_valid", bus_a.sig_valid, 1'b1);
        checkOutput("cnt49_pass",  bus_a.pass,      1'b0);
        checkOutput("cnt49_fail",  bus_a.fail,      1'b1);
        clearA();

        runPairs(24);
        applyStimulus(1'b1, 16'h0001, 1'b0);
        checkOutput("simul_pre_sig", bus_a.signature, 16'h0001);
        applyStimulus(1'b1, 16'h0002, 1'b1);
        checkOutput("simul_sig",   bus_a.signature,   16'h0000);
        checkOutput("simul_cnt",   bus_a.round_count, 16'd50);
        checkOutput("simul_valid", bus_a.sig_valid,   1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("simul_valid1", bus_a.sig_valid, 1'b1);
        checkOutput("simul_pass",   bus_a.pass,      1'b1);
        clearA();

        model_sig = 16'h0000;
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b1, 16'h0001, 1'b0);
            model_sig = misrModel(model_sig, 16'h0001);
        end
        checkOutput("badsig_sig", bus_a.signature, {16'h0000, model_sig});
        applyStimulus(1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("badsig_pass", bus_a.pass, 1'b0);
        checkOutput("badsig_fail", bus_a.fail, 1'b1);
        clearA();

        applyStimulus(1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("zero_round_valid", bus_a.sig_valid,   1'b1);
        checkOutput("zero_round_cnt",   bus_a.round_count, 16'd0);
        checkOutput("zero_round_fail",  bus_a.fail,        1'b1);
        clearA();

        applyStimulus(1'b1, 16'h0001, 1'b0);
        bus_a.MISR_En = 1'b0;
        checkOutput("async_pre_sig", bus_a.signature, 16'h0001);
        #3;
        rstIn = 1'b1;
        #1;
        checkOutput("async_sig",   bus_a.signature,   16'h0000);
        checkOutput("async_cnt",   bus_a.round_count, 16'd0);
        checkOutput("async_sig_b", bus_b.signature,   16'h8000);
        checkOutput("async_cnt_b", bus_b.round_count, 16'd0);
        tick();
        rstIn = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
